// File: rtl/key_debounce.sv
// Synchronizes and debounces active-low pushbuttons into a clean pressed-level bus with press/release pulses.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key stays held.
module key_debounce #(
    parameter int N_KEYS        = 4,
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_KEYS-1:0] key_n_in,
    output logic [N_KEYS-1:0] buttons_export,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
            $error("key_debounce: DB_CYCLES must be >= 2 and repeat timings >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    state_t            state [N_KEYS];
    logic [CNT_W-1:0]  cnt   [N_KEYS];

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]  rpt [N_KEYS];
    // Set once the initial delay has elapsed; later repeats use the shorter period.
    logic [N_KEYS-1:0] rpt_armed;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1          <= '0;
            sync2          <= '0;
            buttons_export <= '0;
            press_pulse    <= '0;
            release_pulse  <= '0;
`ifdef KEY_REPEAT_EN
            rpt_armed      <= '0;
`endif
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
`ifdef KEY_REPEAT_EN
                rpt[i]   <= '0;
`endif
            end
        end else begin
            // Inversion at the first stage so everything downstream is active-high.
            sync1         <= ~key_n_in;
            sync2         <= sync1;
            press_pulse   <= '0;
            release_pulse <= '0;

            for (int i = 0; i < N_KEYS; i++) begin
                case (state[i])
                    RELEASED: begin
                        if (sync2[i]) begin
                            state[i] <= PRESS_PEND;
                            cnt[i]   <= CNT_W'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync2[i]) begin
                            state[i] <= RELEASED;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]          <= HELD;
                            buttons_export[i] <= 1'b1;
                            press_pulse[i]    <= 1'b1;
                            cnt[i]            <= '0;
`ifdef KEY_REPEAT_EN
                            rpt[i]            <= '0;
                            rpt_armed[i]      <= 1'b0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync2[i]) begin
                            state[i] <= RELEASE_PEND;
                            cnt[i]   <= CNT_W'(1);
`ifdef KEY_REPEAT_EN
                            rpt[i]   <= '0;
`endif
                        end
`ifdef KEY_REPEAT_EN
                        else if (!rpt_armed[i] && rpt[i] == DELAY_LAST) begin
                            press_pulse[i] <= 1'b1;
                            rpt[i]         <= '0;
                            rpt_armed[i]   <= 1'b1;
                        end else if (rpt_armed[i] && rpt[i] == PERIOD_LAST) begin
                            press_pulse[i] <= 1'b1;
                            rpt[i]         <= '0;
                        end else begin
                            rpt[i] <= rpt[i] + RPT_W'(1);
                        end
`endif
                    end
                    RELEASE_PEND: begin
                        if (sync2[i]) begin
                            // Bounce back to held: repeats resume on the period cadence.
                            state[i] <= HELD;
                            cnt[i]   <= '0;
`ifdef KEY_REPEAT_EN
                            rpt[i]       <= '0;
                            rpt_armed[i] <= 1'b1;
`endif
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]          <= RELEASED;
                            buttons_export[i] <= 1'b0;
                            release_pulse[i]  <= 1'b1;
                            cnt[i]            <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= RELEASED;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Repeat-pulse expectations follow KEY_REPEAT_EN when it is defined for the build.
module tb_key_debounce;

    logic       clk_clk;
    logic       reset_reset_n;
    logic [3:0] key_n_in;
    logic [3:0] buttons_export;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    int n_checks;
    int n_pass;

    key_debounce #(
        .N_KEYS       (4),
        .DB_CYCLES    (8),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(6)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .key_n_in      (key_n_in),
        .buttons_export(buttons_export),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [3:0] key_n;
        int         cycles;
        logic [3:0] btn;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t       vecs [18];
    logic [3:0] prev_btn;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] b, input logic [3:0] p,
                             input logic [3:0] r);
        check({tag, " buttons"}, buttons_export, b);
        check({tag, " press"}, press_pulse, p);
        check({tag, " release"}, release_pulse, r);
    endtask

    // Intermediate cycles must keep the previous level and show no pulses.
    task automatic apply_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            key_n_in = vecs[v].key_n;
            for (int c = 1; c < vecs[v].cycles; c++) begin
                step();
                check_all($sformatf("vec%0d cyc%0d", v, c), prev_btn, 4'b0000, 4'b0000);
            end
            step();
            check_all($sformatf("vec%0d end", v), vecs[v].btn, vecs[v].prs, vecs[v].rel);
            prev_btn = vecs[v].btn;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rep;
        bit         rep_en;
        n_checks = 0;
        n_pass   = 0;
`ifdef KEY_REPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif

        vecs[0]  = '{4'b1111, 3,  4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1110, 9,  4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1110, 1,  4'b0001, 4'b0001, 4'b0000};
        vecs[3]  = '{4'b1110, 1,  4'b0001, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b1110, 16, 4'b0001, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b1111, 9,  4'b0001, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0001};
        vecs[7]  = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b1101, 5,  4'b0000, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1111, 3,  4'b0000, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1101, 5,  4'b0000, 4'b0000, 4'b0000};
        vecs[11] = '{4'b1111, 12, 4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0101, 9,  4'b0000, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0101, 1,  4'b1010, 4'b1010, 4'b0000};
        vecs[14] = '{4'b0101, 1,  4'b1010, 4'b0000, 4'b0000};
        vecs[15] = '{4'b1111, 9,  4'b1010, 4'b0000, 4'b0000};
        vecs[16] = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b1010};
        vecs[17] = '{4'b1111, 1,  4'b0000, 4'b0000, 4'b0000};

        // Reset held with every key down, then released: all keys accepted together.
        reset_reset_n = 1'b0;
        key_n_in      = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_all("in reset", 4'b0000, 4'b0000, 4'b0000);
        end
        reset_reset_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            check_all($sformatf("post-reset cyc%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("post-reset accept", 4'b1111, 4'b1111, 4'b0000);
        step();
        check_all("post-reset pulse clear", 4'b1111, 4'b0000, 4'b0000);
        key_n_in = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            step();
            check_all($sformatf("all release cyc%0d", c), 4'b1111, 4'b0000, 4'b0000);
        end
        step();
        check_all("all release accept", 4'b0000, 4'b0000, 4'b1111);
        step();
        check_all("all release clear", 4'b0000, 4'b0000, 4'b0000);

        // Clean press/release, glitch rejection, simultaneous press of keys 1 and 3.
        prev_btn = 4'b0000;
        apply_range(0, 14);

        // Keys 1 and 3 held; edge offset k counts from the acceptance edge.
        for (int k = 2; k <= 50; k++) begin
            step();
            exp_rep = (rep_en && (k == 20 || (k > 20 && (k - 20) % 6 == 0))) ? 4'b1010 : 4'b0000;
            check_all($sformatf("hold k=%0d", k), 4'b1010, exp_rep, 4'b0000);
        end

        apply_range(15, 17);

        // Reset in the middle of debouncing key 2 while key 0 is held.
        key_n_in = 4'b1110;
        for (int c = 1; c <= 9; c++) step();
        step();
        check_all("pre-reset key0 accept", 4'b0001, 4'b0001, 4'b0000);
        step();
        key_n_in = 4'b1010;
        for (int c = 1; c <= 4; c++) step();
        check_all("key2 pending", 4'b0001, 4'b0000, 4'b0000);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_all("async reset", 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        check_all("reset held", 4'b0000, 4'b0000, 4'b0000);
        reset_reset_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            check_all($sformatf("re-accept cyc%0d", c), 4'b0000, 4'b0000, 4'b0000);
        end
        step();
        check_all("re-accept", 4'b0101, 4'b0101, 4'b0000);
        step();
        check_all("re-accept clear", 4'b0101, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
